// File: rtl/mux_skid_pkg.sv
// Shared types and helpers for mux_skid_reg and its skid_buffer.
// The entry struct is declared inside mux_skid_reg because its widths come from that module's parameters.
package mux_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int PAR_MAX_W = 256;

    // Even parity: XOR reduction, callers zero-extend narrower data.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready skid buffer over an opaque payload.
// in_ready is registered, so there is no combinational out_ready -> in_ready path.
import mux_skid_pkg::*;

module skid_buffer #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    logic [PW-1:0] main_r, skid_r, main_n, skid_n;
    logic          main_v_r, skid_v_r, main_v_n, skid_v_n;
    logic          in_ready_r, in_ready_n;
    logic          accept_s, drain_s;
    state_t        state_s;

    assign accept_s = in_valid && in_ready_r;
    assign drain_s  = main_v_r && out_ready;

    // Occupancy state derived from the two valid bits.
    always_comb begin
        case ({main_v_r, skid_v_r})
            2'b00:   state_s = EMPTY;
            2'b10:   state_s = ONE;
            2'b11:   state_s = TWO;
            default: state_s = EMPTY;
        endcase
    end

    // Next-state logic; clr wins over a simultaneous accept and leaves the data stale.
    always_comb begin
        main_n   = main_r;
        skid_n   = skid_r;
        main_v_n = main_v_r;
        skid_v_n = skid_v_r;
        case (state_s)
            EMPTY: begin
                skid_v_n = 1'b0;
                if (accept_s) begin
                    main_n   = in_data;
                    main_v_n = 1'b1;
                end else begin
                    main_v_n = 1'b0;
                end
            end
            ONE: begin
                if (accept_s && drain_s) begin
                    main_n = in_data;
                end else if (accept_s) begin
                    skid_n   = in_data;
                    skid_v_n = 1'b1;
                end else if (drain_s) begin
                    main_v_n = 1'b0;
                end else begin
                    main_v_n = 1'b1;
                end
            end
            TWO: begin
                if (drain_s) begin
                    main_n   = skid_r;
                    skid_v_n = 1'b0;
                end else begin
                    skid_v_n = 1'b1;
                end
            end
            default: begin
                main_v_n = 1'b0;
                skid_v_n = 1'b0;
            end
        endcase
        if (clr) begin
            main_n   = main_r;
            skid_n   = skid_r;
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else begin
            main_n = main_n;
        end
        in_ready_n = !(main_v_n && skid_v_n);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_r     <= '0;
            skid_r     <= '0;
            main_v_r   <= 1'b0;
            skid_v_r   <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            main_r     <= main_n;
            skid_r     <= skid_n;
            main_v_r   <= main_v_n;
            skid_v_r   <= skid_v_n;
            in_ready_r <= in_ready_n;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_v_r;
    assign out_data  = main_r;

endmodule

// File: rtl/mux_skid_reg.sv
// NUM_SRC:1 registered mux with a valid/ready output backed by a 2-entry skid buffer.
// Optional per-item parity output dout_par when MUX_SKID_PARITY_EN is defined.
import mux_skid_pkg::*;

module mux_skid_reg #(
    parameter  int WIDTH   = 8,
    parameter  int NUM_SRC = 4,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] din,
    input  logic                     clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         dout,
    output logic [SEL_W-1:0]         out_src,
    output logic                     out_err
`ifdef MUX_SKID_PARITY_EN
    ,
    output logic                     dout_par
`endif
);

    typedef struct packed {
        logic             err;
        logic [SEL_W-1:0] src;
        logic [WIDTH-1:0] data;
`ifdef MUX_SKID_PARITY_EN
        logic             par;
`endif
    } entry_t;

    localparam int               PW        = $bits(entry_t);
    localparam int               NSLOT     = 1 << SEL_W;
    localparam logic [SEL_W:0]   NUM_SRC_W = (SEL_W + 1)'(NUM_SRC);

    logic [WIDTH-1:0] src_s [NSLOT];
    entry_t           in_entry_s;
    entry_t           out_entry_s;
    logic [PW-1:0]    out_data_s;

    // Unused select codes alias source 0, so an out-of-range sel needs no extra mux leg.
    for (genvar k = 0; k < NSLOT; k++) begin : g_src
        if (k < NUM_SRC) begin : g_in
            assign src_s[k] = din[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign src_s[k] = din[WIDTH-1:0];
        end
    end

    // Build the entry captured on an input accept.
    always_comb begin
        in_entry_s      = '0;
        in_entry_s.err  = ({1'b0, sel} >= NUM_SRC_W);
        in_entry_s.src  = sel;
        in_entry_s.data = src_s[sel];
`ifdef MUX_SKID_PARITY_EN
        in_entry_s.par  = even_parity(PAR_MAX_W'(src_s[sel]));
`endif
    end

    skid_buffer #(
        .PW(PW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_entry_s),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data_s)
    );

    assign out_entry_s = out_data_s;
    assign dout        = out_entry_s.data;
    assign out_src     = out_entry_s.src;
    assign out_err     = out_entry_s.err;
`ifdef MUX_SKID_PARITY_EN
    assign dout_par    = out_entry_s.par;
`endif

endmodule

// File: tb/tb_mux_skid_reg.sv
// Scoreboard bench for mux_skid_reg: a 4-source instance plus a 3-source instance for bad selects.
module tb_mux_skid_reg;

    typedef struct {
        logic [7:0] data;
        logic [1:0] src;
        logic       err;
        logic       par;
        bit         lat;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
    logic [1:0]  sel = 2'd0, out_src;
    logic [31:0] din = 32'h0;
    logic [7:0]  dout;
    logic        in_valid3 = 1'b0, in_ready3, out_valid3, out_err3;
    logic        out_ready3 = 1'b1;
    logic [1:0]  sel3 = 2'd0, out_src3;
    logic [23:0] din3 = 24'h0;
    logic [7:0]  dout3;
`ifdef MUX_SKID_PARITY_EN
    logic        dout_par, dout_par3;
`endif

    exp_t q4[$];
    exp_t q3[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_skid_reg #(.WIDTH(8), .NUM_SRC(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .din(din),
        .clr(clr), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .out_src(out_src), .out_err(out_err)
`ifdef MUX_SKID_PARITY_EN
        , .dout_par(dout_par)
`endif
    );

    mux_skid_reg #(.WIDTH(8), .NUM_SRC(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .sel(sel3), .din(din3),
        .clr(clr), .out_valid(out_valid3), .out_ready(out_ready3), .dout(dout3),
        .out_src(out_src3), .out_err(out_err3)
`ifdef MUX_SKID_PARITY_EN
        , .dout_par(dout_par3)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send4(input logic [1:0] s, input logic [7:0] d, input logic e_err, input bit lat);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        sel      = s;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout4: in_ready stayed 0 for 50 cycles");
        end
        e.data = d; e.src = s; e.err = e_err; e.par = ^d; e.lat = lat; e.cyc = cyc;
        q4.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send3(input logic [1:0] s, input logic [7:0] d, input logic e_err);
        exp_t e;
        int   n;
        in_valid3 = 1'b1;
        sel3      = s;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready3) break;
        end
        if (n == 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout3: in_ready stayed 0 for 50 cycles");
        end
        e.data = d; e.src = s; e.err = e_err; e.par = ^d; e.lat = 1'b0; e.cyc = cyc;
        q3.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 4-source instance: stall stability and in-order delivery.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !out_ready && q4.size() > 0) begin
                chk("stall_dout", 32'(dout), 32'(q4[0].data));
                chk("stall_src", 32'(out_src), 32'(q4[0].src));
            end
            if (out_valid && out_ready) begin
                if (q4.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_item4: got dout %0h expected none", dout);
                end else begin
                    exp_t e;
                    e = q4.pop_front();
                    chk("dout", 32'(dout), 32'(e.data));
                    chk("out_src", 32'(out_src), 32'(e.src));
                    chk("out_err", 32'(out_err), 32'(e.err));
`ifdef MUX_SKID_PARITY_EN
                    chk("dout_par", 32'(dout_par), 32'(e.par));
`endif
                    if (e.lat) chk("latency", 32'(cyc), 32'(e.cyc + 1));
                end
            end
        end
    end

    // Monitor for the 3-source instance.
    always @(negedge clk) begin
        if (!rst && out_valid3 && out_ready3) begin
            if (q3.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_item3: got dout %0h expected none", dout3);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("dout3", 32'(dout3), 32'(e.data));
                chk("out_src3", 32'(out_src3), 32'(e.src));
                chk("out_err3", 32'(out_err3), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Streaming, one item per cycle.
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        out_ready = 1'b1;
        send4(2'd0, 8'h11, 1'b0, 1'b1);
        send4(2'd1, 8'h22, 1'b0, 1'b1);
        send4(2'd2, 8'h33, 1'b0, 1'b1);
        send4(2'd3, 8'h44, 1'b0, 1'b1);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure: A then B while stalled.
        din = {8'h00, 8'h00, 8'h5A, 8'hA5};
        out_ready = 1'b0;
        send4(2'd0, 8'hA5, 1'b0, 1'b0);
        send4(2'd1, 8'h5A, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 32'(q4.size()), 32'd0);
        chk("bp_in_ready_high", 32'(in_ready), 32'd1);

        // Bad select on the 3-source instance.
        din3 = {8'h33, 8'h22, 8'h7E};
        send3(2'd3, 8'h7E, 1'b1);
        send3(2'd1, 8'h22, 1'b0);
        in_valid3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bad_sel_drained", 32'(q3.size()), 32'd0);

`ifdef MUX_SKID_PARITY_EN
        din = {8'h03, 8'h07, 8'h00, 8'h00};
        send4(2'd2, 8'h07, 1'b0, 1'b0);
        send4(2'd3, 8'h03, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`endif

        // clr with a simultaneous accept in state ONE.
        din = {8'hC3, 8'hB2, 8'h00, 8'h00};
        out_ready = 1'b0;
        send4(2'd2, 8'hB2, 1'b0, 1'b0);
        in_valid = 1'b1;
        sel = 2'd3;
        clr = 1'b1;
        @(negedge clk);
        chk("clr_pre_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        q4.delete();
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("clr_no_item", 32'(out_valid), 32'd0);

        // Asynchronous reset while full.
        din = {8'h00, 8'h00, 8'h69, 8'h96};
        out_ready = 1'b0;
        send4(2'd0, 8'h96, 1'b0, 1'b0);
        send4(2'd1, 8'h69, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        q4.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("arst_no_item", 32'(out_valid), 32'd0);

        chk("q4_empty", 32'(q4.size()), 32'd0);
        chk("q3_empty", 32'(q3.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
